// File: rtl/pq_enq_fifo.sv
// Upstream staging FIFO for the shift-register priority queue: buffers producer
// key/value pushes and issues them to the PQ in push order, forwarding dequeues.
package pq_pkg;
  localparam int KEY_WIDTH = 8;
  localparam int VAL_WIDTH = 8;
endpackage

module pq_enq_fifo #(
  parameter int KW    = pq_pkg::KEY_WIDTH,
  parameter int VW    = pq_pkg::VAL_WIDTH,
  parameter int DEPTH = 4,
  parameter int CNTW  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_push,
  input  logic [KW+VW-1:0]             kv_in,
  output logic                         in_ready,
  input  logic                         deq_req,
  input  logic                         pq_full,
  input  logic                         pq_empty,
  output logic [KW+VW-1:0]             pq_kvi,
  output logic                         pq_enq,
  output logic                         pq_deq,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         ovf,
  output logic                         deq_drop,
  output logic [CNTW-1:0]              enq_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [KW+VW-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             ovf_q, ovf_d;
  logic             deq_drop_q, deq_drop_d;
  logic [CNTW-1:0]  enq_cnt_q, enq_cnt_d;
  logic             push_ok;

  // Producer handshake: a push transfers when in_push && in_ready at the rising
  // edge; in_ready depends only on the registered level, never on a same-cycle pop.
  assign in_ready = (level_q < LW'(DEPTH));
  assign push_ok  = in_push && in_ready;

  // A full PQ still takes an enqueue when it is dequeued in the same cycle.
  assign pq_deq   = deq_req && !pq_empty;
  assign pq_enq   = (level_q != '0) && (!pq_full || pq_deq);
  assign pq_kvi   = mem_q[rd_ptr_q];

  assign level    = level_q;
  assign ovf      = ovf_q;
  assign deq_drop = deq_drop_q;
  assign enq_cnt  = enq_cnt_q;

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    level_d    = level_q;
    ovf_d      = ovf_q || (in_push && !in_ready);
    deq_drop_d = deq_req && pq_empty;
    enq_cnt_d  = enq_cnt_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pq_enq) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      if (enq_cnt_q != '1) enq_cnt_d = enq_cnt_q + CNTW'(1);
    end
    case ({push_ok, pq_enq})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Storage is deliberately not reset; the head is meaningless while level is 0.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem_q[wr_ptr_q] <= kv_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      level_q    <= '0;
      ovf_q      <= 1'b0;
      deq_drop_q <= 1'b0;
      enq_cnt_q  <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      level_q    <= level_d;
      ovf_q      <= ovf_d;
      deq_drop_q <= deq_drop_d;
      enq_cnt_q  <= enq_cnt_d;
    end
  end
endmodule

// File: tb/tb_pq_enq_fifo.sv
// Bench for pq_enq_fifo: directed scenarios plus random traffic against a
// queue-based reference model of the staging FIFO.
module tb_pq_enq_fifo;
  localparam int KW    = pq_pkg::KEY_WIDTH;
  localparam int VW    = pq_pkg::VAL_WIDTH;
  localparam int W     = KW + VW;
  localparam int DEPTH = 4;
  localparam int CNTW  = 4;
  localparam int LW    = $clog2(DEPTH+1);
  localparam int CMAX  = (1 << CNTW) - 1;

  logic            clk;
  logic            rst;
  logic            in_push;
  logic [W-1:0]    kv_in;
  logic            in_ready;
  logic            deq_req;
  logic            pq_full;
  logic            pq_empty;
  logic [W-1:0]    pq_kvi;
  logic            pq_enq;
  logic            pq_deq;
  logic [LW-1:0]   level;
  logic            ovf;
  logic            deq_drop;
  logic [CNTW-1:0] enq_cnt;

  int checks   = 0;
  int failures = 0;

  // reference model
  logic [W-1:0] exp_q[$];
  bit           m_ovf;
  bit           m_drop;
  int           m_cnt;

  pq_enq_fifo #(.KW(KW), .VW(VW), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .in_push(in_push), .kv_in(kv_in), .in_ready(in_ready),
    .deq_req(deq_req), .pq_full(pq_full), .pq_empty(pq_empty), .pq_kvi(pq_kvi),
    .pq_enq(pq_enq), .pq_deq(pq_deq), .level(level), .ovf(ovf),
    .deq_drop(deq_drop), .enq_cnt(enq_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] mk(input int k, input int v);
    return {KW'(k), VW'(v)};
  endfunction

  // driver: called at a falling edge, settles inputs, leaves time for combinational outputs
  task automatic drive(input bit p, input logic [W-1:0] kv, input bit d,
                       input bit f, input bit e, input bit r = 1'b0);
    rst = r; in_push = p; kv_in = kv; deq_req = d; pq_full = f; pq_empty = e;
    #1;
  endtask

  // advance one clock and update the model from the inputs presented at the edge
  task automatic tick();
    bit           acc, pop;
    logic [W-1:0] kv;
    acc = in_push && (exp_q.size() < DEPTH);
    pop = (exp_q.size() != 0) && (!pq_full || (deq_req && !pq_empty));
    kv  = kv_in;
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      m_ovf = 0; m_drop = 0; m_cnt = 0;
    end else begin
      if (pop) begin
        void'(exp_q.pop_front());
        if (m_cnt < CMAX) m_cnt++;
      end
      if (acc) exp_q.push_back(kv);
      else if (in_push) m_ovf = 1;
      m_drop = deq_req && pq_empty;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive(0, '0, 0, 0, 1, 1); tick(); tick();
    drive(0, '0, 0, 0, 1);
    checks++; if (level !== 0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%0b exp=0", ovf); end
    checks++; if (deq_drop !== 1'b0) begin failures++; $display("FAIL reset_deq_drop got=%0b exp=0", deq_drop); end
    checks++; if (enq_cnt !== 0) begin failures++; $display("FAIL reset_enq_cnt got=%0d exp=0", enq_cnt); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    checks++; if (pq_enq !== 1'b0) begin failures++; $display("FAIL reset_pq_enq got=%0b exp=0", pq_enq); end
  endtask

  task automatic test_single();
    drive(1, mk(8, 14), 0, 0, 1);
    checks++; if (pq_enq !== 1'b0) begin failures++; $display("FAIL single_no_bypass got=%0b exp=0", pq_enq); end
    tick();
    drive(0, '0, 0, 0, 1);
    checks++; if (level !== 1) begin failures++; $display("FAIL single_level1 got=%0d exp=1", level); end
    checks++; if (pq_enq !== 1'b1) begin failures++; $display("FAIL single_enq got=%0b exp=1", pq_enq); end
    checks++; if (pq_kvi !== mk(8, 14)) begin failures++; $display("FAIL single_kvi got=%0h exp=%0h", pq_kvi, mk(8, 14)); end
    tick();
    drive(0, '0, 0, 0, 1);
    checks++; if (level !== 0) begin failures++; $display("FAIL single_level0 got=%0d exp=0", level); end
    checks++; if (enq_cnt !== 1) begin failures++; $display("FAIL single_enq_cnt got=%0d exp=1", enq_cnt); end
  endtask

  task automatic test_overflow();
    logic [W-1:0] kvs[5];
    kvs[0] = mk(9, 10); kvs[1] = mk(9, 11); kvs[2] = mk(9, 12); kvs[3] = mk(3, 13); kvs[4] = mk(1, 1);
    for (int i = 0; i < 5; i++) begin
      drive(1, kvs[i], 0, 1, 0);
      checks++; if (pq_enq !== 1'b0) begin failures++; $display("FAIL ovf_enq[%0d] got=%0b exp=0", i, pq_enq); end
      checks++; if (in_ready !== (i < 4)) begin failures++; $display("FAIL ovf_in_ready[%0d] got=%0b exp=%0b", i, in_ready, i < 4); end
      tick();
    end
    drive(0, '0, 0, 1, 0);
    checks++; if (level !== 4) begin failures++; $display("FAIL ovf_level got=%0d exp=4", level); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL ovf_full_ready got=%0b exp=0", in_ready); end
    checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%0b exp=1", ovf); end
    checks++; if (pq_enq !== 1'b0) begin failures++; $display("FAIL ovf_enq_end got=%0b exp=0", pq_enq); end
  endtask

  task automatic test_enq_deq_full();
    drive(0, '0, 1, 1, 0);
    checks++; if (pq_deq !== 1'b1) begin failures++; $display("FAIL full_deq got=%0b exp=1", pq_deq); end
    checks++; if (pq_enq !== 1'b1) begin failures++; $display("FAIL full_enq got=%0b exp=1", pq_enq); end
    checks++; if (pq_kvi !== mk(9, 10)) begin failures++; $display("FAIL full_kvi got=%0h exp=%0h", pq_kvi, mk(9, 10)); end
    tick();
    drive(0, '0, 0, 1, 0);
    checks++; if (level !== 3) begin failures++; $display("FAIL full_level got=%0d exp=3", level); end
    checks++; if (pq_kvi !== mk(9, 11)) begin failures++; $display("FAIL full_head got=%0h exp=%0h", pq_kvi, mk(9, 11)); end
    checks++; if (enq_cnt !== 2) begin failures++; $display("FAIL full_enq_cnt got=%0d exp=2", enq_cnt); end
  endtask

  task automatic test_deq_drop();
    drive(0, '0, 1, 0, 1);
    checks++; if (pq_deq !== 1'b0) begin failures++; $display("FAIL drop_pq_deq got=%0b exp=0", pq_deq); end
    checks++; if (pq_enq !== 1'b1) begin failures++; $display("FAIL drop_no_stall got=%0b exp=1", pq_enq); end
    tick();
    drive(0, '0, 0, 1, 0);
    checks++; if (deq_drop !== 1'b1) begin failures++; $display("FAIL drop_pulse got=%0b exp=1", deq_drop); end
    checks++; if (level !== 2) begin failures++; $display("FAIL drop_level got=%0d exp=2", level); end
    tick();
    drive(0, '0, 0, 1, 0);
    checks++; if (deq_drop !== 1'b0) begin failures++; $display("FAIL drop_one_cycle got=%0b exp=0", deq_drop); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 2*DEPTH; i++) begin
      drive(1, W'($urandom), 0, 0, 0);
      checks++; if (level !== 2) begin failures++; $display("FAIL b2b_level[%0d] got=%0d exp=2", i, level); end
      checks++; if (pq_enq !== 1'b1) begin failures++; $display("FAIL b2b_enq[%0d] got=%0b exp=1", i, pq_enq); end
      checks++; if (pq_kvi !== exp_q[0]) begin failures++; $display("FAIL b2b_order[%0d] got=%0h exp=%0h", i, pq_kvi, exp_q[0]); end
      tick();
    end
    drive(0, '0, 0, 1, 0);
    checks++; if (level !== 2) begin failures++; $display("FAIL b2b_level_end got=%0d exp=2", level); end
    checks++; if (pq_kvi !== exp_q[0]) begin failures++; $display("FAIL b2b_head_end got=%0h exp=%0h", pq_kvi, exp_q[0]); end
  endtask

  task automatic test_saturate();
    drive(0, '0, 0, 0, 1, 1); tick();
    for (int i = 0; i < 20; i++) begin
      drive(1, W'($urandom), 0, 0, 0);
      tick();
    end
    drive(0, '0, 0, 0, 1);
    checks++; if (enq_cnt !== CNTW'(CMAX)) begin failures++; $display("FAIL sat_cnt got=%0d exp=%0d", enq_cnt, CMAX); end
    checks++; if (pq_enq !== 1'b1) begin failures++; $display("FAIL sat_enq got=%0b exp=1", pq_enq); end
    tick();
    drive(0, '0, 0, 0, 1);
    checks++; if (enq_cnt !== CNTW'(CMAX)) begin failures++; $display("FAIL sat_hold got=%0d exp=%0d", enq_cnt, CMAX); end
    checks++; if (level !== 0) begin failures++; $display("FAIL sat_level got=%0d exp=0", level); end
  endtask

  task automatic test_random();
    bit e_enq, e_deq;
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) < 6, W'($urandom), $urandom_range(0, 9) < 3,
            $urandom_range(0, 9) < 4, $urandom_range(0, 3) == 0, $urandom_range(0, 99) == 0);
      e_deq = deq_req && !pq_empty;
      e_enq = (exp_q.size() != 0) && (!pq_full || e_deq);
      checks++; if (in_ready !== (exp_q.size() < DEPTH)) begin failures++; $display("FAIL rnd_in_ready[%0d] got=%0b exp=%0b", i, in_ready, exp_q.size() < DEPTH); end
      checks++; if (pq_deq !== e_deq) begin failures++; $display("FAIL rnd_pq_deq[%0d] got=%0b exp=%0b", i, pq_deq, e_deq); end
      checks++; if (pq_enq !== e_enq) begin failures++; $display("FAIL rnd_pq_enq[%0d] got=%0b exp=%0b", i, pq_enq, e_enq); end
      if (exp_q.size() != 0) begin
        checks++; if (pq_kvi !== exp_q[0]) begin failures++; $display("FAIL rnd_kvi[%0d] got=%0h exp=%0h", i, pq_kvi, exp_q[0]); end
      end
      checks++; if (level !== exp_q.size()) begin failures++; $display("FAIL rnd_level[%0d] got=%0d exp=%0d", i, level, exp_q.size()); end
      checks++; if (ovf !== m_ovf) begin failures++; $display("FAIL rnd_ovf[%0d] got=%0b exp=%0b", i, ovf, m_ovf); end
      checks++; if (deq_drop !== m_drop) begin failures++; $display("FAIL rnd_deq_drop[%0d] got=%0b exp=%0b", i, deq_drop, m_drop); end
      checks++; if (enq_cnt !== CNTW'(m_cnt)) begin failures++; $display("FAIL rnd_enq_cnt[%0d] got=%0d exp=%0d", i, enq_cnt, m_cnt); end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    drive(0, '0, 0, 0, 1, 1); tick();
    for (int i = 0; i < 5; i++) begin
      drive(1, mk(i, i + 1), 0, 1, 0); tick();
    end
    drive(0, '0, 0, 0, 0); tick();
    drive(0, '0, 0, 0, 0, 1);
    checks++; if (level !== 3) begin failures++; $display("FAIL rstmid_pre_level got=%0d exp=3", level); end
    checks++; if (pq_enq !== 1'b1) begin failures++; $display("FAIL rstmid_pre_enq got=%0b exp=1", pq_enq); end
    checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL rstmid_pre_ovf got=%0b exp=1", ovf); end
    tick();
    drive(0, '0, 0, 0, 1);
    checks++; if (level !== 0) begin failures++; $display("FAIL rstmid_level got=%0d exp=0", level); end
    checks++; if (pq_enq !== 1'b0) begin failures++; $display("FAIL rstmid_enq got=%0b exp=0", pq_enq); end
    checks++; if (pq_deq !== 1'b0) begin failures++; $display("FAIL rstmid_deq got=%0b exp=0", pq_deq); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL rstmid_ovf got=%0b exp=0", ovf); end
    checks++; if (enq_cnt !== 0) begin failures++; $display("FAIL rstmid_enq_cnt got=%0d exp=0", enq_cnt); end
  endtask

  initial begin
    rst = 1'b1; in_push = 1'b0; kv_in = '0; deq_req = 1'b0; pq_full = 1'b0; pq_empty = 1'b1;
    m_ovf = 0; m_drop = 0; m_cnt = 0;
    @(negedge clk);
    test_reset();
    test_single();
    test_overflow();
    test_enq_deq_full();
    test_deq_drop();
    test_back_to_back();
    test_saturate();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pq_enq_fifo.md
Name: pq_enq_fifo

Overview:
- Upstream staging buffer for the shift-register priority queue (sr_pq).
- Collects key/value enqueue requests from a producer into a small FIFO.
- Forwards the oldest entry to the PQ as soon as the PQ can take it, and passes through consumer dequeue requests.
- Moves the PQ full back-pressure off the producer and lets enq and deq happen in the same cycle when the PQ is full.

Parameters:
- KW, pq_pkg::KEY_WIDTH, key field width.
- VW, pq_pkg::VAL_WIDTH, value field width.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- CNTW, 16, width of the issued-enqueue statistics counter.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_push  in  1  producer offers kv_in this cycle.
- kv_in  in  KW+VW  {key,val}, key in the MSBs (same packing as the PQ kvi).
- in_ready  out  1  FIFO can accept a push this cycle.
- deq_req  in  1  consumer requests a PQ dequeue.
- pq_full  in  1  PQ full flag, current cycle.
- pq_empty  in  1  PQ empty flag, current cycle.
- pq_kvi  out  KW+VW  FIFO head entry, driven to the PQ kvi.
- pq_enq  out  1  enqueue strobe to the PQ.
- pq_deq  out  1  dequeue strobe to the PQ.
- level  out  $clog2(DEPTH+1)  current FIFO occupancy.
- ovf  out  1  sticky flag: a push was dropped.
- deq_drop  out  1  registered one-cycle pulse: deq_req arrived while the PQ was empty.
- enq_cnt  out  CNTW  saturating count of enqueues issued to the PQ.

Behaviour:
Reset:
- rst sampled high at a rising edge clears rd_ptr, wr_ptr, level, ovf, deq_drop and enq_cnt to 0.
- The FIFO storage is not cleared; pq_kvi is don't-care while level==0.
- Reset mid-operation discards all buffered entries. pq_enq and pq_deq are 0 during the cycle after reset and stay 0 until new stimulus arrives.
- Reset has priority over every other event.

FIFO:
- Circular buffer indexed by rd_ptr and wr_ptr, each $clog2(DEPTH) bits and wrapping modulo DEPTH.
- level is held in its own register.
- in_ready = (level < DEPTH). It is combinational from level and does not consider a pop in the same cycle.
- A push is accepted when in_push && in_ready: the entry is written at wr_ptr and wr_ptr increments.
- A push with in_push && !in_ready is dropped, FIFO state is unchanged, and ovf is set. ovf clears only on rst.
- No bypass: a pushed entry can reach the PQ no earlier than the next cycle (minimum latency 1 cycle from push to pq_enq).

Issue logic (combinational, from the current flags):
- pq_deq = deq_req && !pq_empty.
- pq_enq = (level != 0) && (!pq_full || pq_deq).
- The full case is legal because the PQ accepts a simultaneous enq+deq when full.
- pq_kvi = mem[rd_ptr] at all times.
- When pq_enq is high, at the edge rd_ptr increments and enq_cnt increments, holding at 2^CNTW-1 when saturated.

Other registered updates:
- Simultaneous accepted push and pq_enq: level is unchanged and both pointers advance.
- deq_drop is registered high for one cycle if deq_req && pq_empty was true at the previous edge.
- A dropped deq never stalls enqueue issue.

Ordering:
- Entries reach the PQ strictly in push order.
- Priority ordering is the PQ's responsibility.

Test Plan:
1. After rst, push {8,14} in cycle 1 with the PQ empty and not full -> level=1 at cycle 2. pq_enq=1 with pq_kvi={8,14} in cycle 2. level=0 and enq_cnt=1 in cycle 3.
2. Hold pq_full=1 and push 5 entries {9,10},{9,11},{9,12},{3,13},{1,1} on consecutive cycles -> first 4 accepted, level=4, in_ready=0, 5th dropped, ovf=1, pq_enq=0 throughout.
3. Start from scenario 2's state (pq_full=1, pq_empty=0), then assert deq_req for 1 cycle -> pq_deq=1 and pq_enq=1 in the same cycle with pq_kvi={9,10}. Next cycle level=3 and the head is {9,11}.
4. Set pq_empty=1 and assert deq_req -> pq_deq=0, and deq_drop=1 for exactly one cycle after.
5. Set level=2, then push and issue in the same cycle -> level stays 2 and both pointers advance. Run 2*DEPTH pushes through to check wrap-around order is preserved.
6. Assert rst while level=3 with pq_enq active -> next cycle level=0, pq_enq=0, ovf=0, enq_cnt=0.
